femto_prog_seq: RTL and testbench

- Instruction sequencer directly upstream of the femto core.
- Buffers a short program of 7-bit instruction words (op[2:0], reg_0[1:0], reg_1[1:0], packed as the core's io_in[7:1]).
- Replays the program into the core one word per clock, or one word per step.
- Drives NOP (all zeros) whenever no instruction is issued, so the core never sees stale words.

---
 rtl/femto_pkg.sv | 23 ++
 rtl/femto_prog_mem.sv | 27 ++
 rtl/femto_prog_seq.sv | 120 ++++++++++++
 tb/tb_femto_prog_seq.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/femto_pkg.sv
// Shared definitions for the femto core and its upstream instruction sequencer.
package femto_pkg;

    localparam int OPSIZE  = 3;
    localparam int NUMRF   = 2;
    localparam int SIZE    = 1 << NUMRF;
    localparam int INSTR_W = OPSIZE + 2 * NUMRF;

    // Word layout {op, reg_0, reg_1}, matching the core's io_in[7:1]
    localparam int REG1_LSB = 0;
    localparam int REG0_LSB = NUMRF;
    localparam int OP_LSB   = 2 * NUMRF;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/femto_prog_mem.sv
// Program buffer: synchronous write, asynchronous read; the sequencer registers the output.
module femto_prog_mem
    import femto_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [INSTR_W-1:0] rd_data
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // NOTE: storage is deliberately not reset; prog_len=0 makes stale words unreachable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/femto_prog_seq.sv
// Instruction sequencer feeding the femto core: loads a short program, then replays it
// one word per clock or per step pulse, driving NOP whenever nothing is issued.
module femto_prog_seq
    import femto_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic               wr_valid,
    input  logic [INSTR_W-1:0] wr_data,
    output logic               wr_ready,
    input  logic               start,
    input  logic               step_mode,
    input  logic               step,
    input  logic               loop_en,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic [AW-1:0]      pc,
    output logic [AW:0]        prog_len,
    output logic               busy,
    output logic               done
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    seq_state_t         state;
    logic [INSTR_W-1:0] rd_data;
    logic               wr_fire;
    logic               advance;
    logic               last_word;

    assign wr_ready  = (state == LOAD) && (prog_len < DEPTH_L);
    assign busy      = (state == RUN);
    assign wr_fire   = wr_valid && wr_ready;
    assign advance   = !step_mode || step;
    assign last_word = ({1'b0, pc} == (prog_len - 1'b1));

    femto_prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr (prog_len[AW-1:0]),
        .wr_data (wr_data),
        .rd_addr (pc),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            prog_len    <= '0;
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            // NOTE: default to NOP every edge; only an advancing RUN edge overrides it,
            // so the core can never see a stale word.
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (load_en) begin
                        state    <= LOAD;
                        prog_len <= '0;
                    end else if (start && (prog_len != '0)) begin
                        state <= RUN;
                        pc    <= '0;
                    end
                end

                LOAD: begin
                    if (wr_fire) begin
                        prog_len <= prog_len + 1'b1;
                    end
                    if (!load_en) begin
                        state <= IDLE;
                    end
                end

                RUN: begin
                    if (advance) begin
                        instr_out   <= rd_data;
                        instr_valid <= 1'b1;
                        if (last_word) begin
                            pc <= '0;
                            if (!loop_en) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end

                DONE: begin
                    if (load_en) begin
                        state    <= LOAD;
                        prog_len <= '0;
                        done     <= 1'b0;
                    end else if (start) begin
                        state <= RUN;
                        pc    <= '0;
                        done  <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_femto_prog_seq.sv
// Self-checking bench for femto_prog_seq: directed scenarios plus randomized step/loop runs
// compared against a program-queue reference model.
module tb_femto_prog_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_en;
    logic       wr_valid;
    logic [6:0] wr_data;
    logic       wr_ready;
    logic       start;
    logic       step_mode;
    logic       step;
    logic       loop_en;
    logic [6:0] instr_out;
    logic       instr_valid;
    logic [3:0] pc;
    logic [4:0] prog_len;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    logic [6:0] prog[$];

    always #5 clk = ~clk;

    femto_prog_seq dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .start       (start),
        .step_mode   (step_mode),
        .step        (step),
        .loop_en     (loop_en),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .pc          (pc),
        .prog_len    (prog_len),
        .busy        (busy),
        .done        (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Loads the words in prog; load_en drops together with the final write.
    task automatic load_prog();
        load_en = 1'b1;
        tick();
        foreach (prog[i]) begin
            wr_valid = 1'b1;
            wr_data  = prog[i];
            load_en  = (i != prog.size() - 1);
            tick();
        end
        wr_valid = 1'b0;
        load_en  = 1'b0;
        if (prog.size() == 0) tick();
        total++;
        if (prog_len !== 5'(prog.size()) || busy !== 1'b0) begin
            bad++;
            $display("FAIL load_len: prog_len=%0d busy=%0b, required prog_len=%0d busy=0",
                     prog_len, busy, prog.size());
        end
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (instr_out !== 7'h00 || instr_valid !== 1'b0 || wr_ready !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || pc !== 4'd0 || prog_len !== 5'd0) begin
            bad++;
            $display("FAIL reset_state: out=%0h v=%0b rdy=%0b busy=%0b done=%0b pc=%0d len=%0d, required all zero",
                     instr_out, instr_valid, wr_ready, busy, done, pc, prog_len);
        end
    endtask

    task automatic test_idle_start();
        start_run();
        total++;
        if (busy !== 1'b0 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL empty_start: busy=%0b v=%0b, required 0 0", busy, instr_valid);
        end
        prog = '{7'h33, 7'h44};
        load_prog();
        start   = 1'b1;
        load_en = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (wr_ready !== 1'b1 || busy !== 1'b0 || prog_len !== 5'd0) begin
            bad++;
            $display("FAIL load_priority: rdy=%0b busy=%0b len=%0d, required 1 0 0",
                     wr_ready, busy, prog_len);
        end
        load_en = 1'b0;
        tick();
        start_run();
        total++;
        if (busy !== 1'b0 || prog_len !== 5'd0) begin
            bad++;
            $display("FAIL cleared_start: busy=%0b len=%0d, required 0 0", busy, prog_len);
        end
    endtask

    task automatic test_basic();
        prog = '{7'h15, 7'h2A, 7'h7F};
        load_prog();
        start_run();
        total++;
        if (busy !== 1'b1 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL run_entry: busy=%0b v=%0b, required 1 0", busy, instr_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (instr_valid !== 1'b1 || instr_out !== prog[i]) begin
                bad++;
                $display("FAIL basic_issue[%0d]: out=%0h v=%0b, required %0h 1",
                         i, instr_out, instr_valid, prog[i]);
            end
        end
        tick();
        total++;
        if (done !== 1'b1 || instr_valid !== 1'b0 || instr_out !== 7'h00 ||
            busy !== 1'b0 || prog_len !== 5'd3) begin
            bad++;
            $display("FAIL basic_done: done=%0b v=%0b out=%0h busy=%0b len=%0d, required 1 0 0 0 3",
                     done, instr_valid, instr_out, busy, prog_len);
        end
        start_run();
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b1 || instr_out !== 7'h15 || instr_valid !== 1'b1) begin
            bad++;
            $display("FAIL restart: done=%0b busy=%0b out=%0h v=%0b, required 0 1 15 1",
                     done, busy, instr_out, instr_valid);
        end
        repeat (3) tick();
        load_en = 1'b1;
        start   = 1'b1;
        tick();
        load_en = 1'b0;
        start   = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b1 || prog_len !== 5'd0) begin
            bad++;
            $display("FAIL done_to_load: done=%0b busy=%0b rdy=%0b len=%0d, required 0 0 1 0",
                     done, busy, wr_ready, prog_len);
        end
        tick();
    endtask

    task automatic test_full();
        load_en = 1'b1;
        tick();
        for (int i = 1; i <= 17; i++) begin
            total++;
            if (wr_ready !== (i <= 16)) begin
                bad++;
                $display("FAIL full_ready[%0d]: rdy=%0b, required %0b", i, wr_ready, (i <= 16));
            end
            wr_valid = 1'b1;
            wr_data  = 7'(i);
            tick();
        end
        wr_valid = 1'b0;
        total++;
        if (wr_ready !== 1'b0 || prog_len !== 5'd16) begin
            bad++;
            $display("FAIL full_len: rdy=%0b len=%0d, required 0 16", wr_ready, prog_len);
        end
        load_en = 1'b0;
        tick();
        start_run();
        for (int i = 0; i < 16; i++) begin
            tick();
            total++;
            if (instr_valid !== 1'b1 || instr_out !== 7'(i + 1)) begin
                bad++;
                $display("FAIL full_issue[%0d]: out=%0h v=%0b, required %0h 1",
                         i, instr_out, instr_valid, i + 1);
            end
        end
        tick();
        total++;
        if (done !== 1'b1 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL full_done: done=%0b v=%0b, required 1 0", done, instr_valid);
        end
    endtask

    task automatic test_loop();
        prog = '{7'h0A, 7'h0B};
        load_prog();
        loop_en = 1'b1;
        start_run();
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (instr_valid !== 1'b1 || instr_out !== prog[i % 2]) begin
                bad++;
                $display("FAIL loop_issue[%0d]: out=%0h v=%0b, required %0h 1",
                         i, instr_out, instr_valid, prog[i % 2]);
            end
        end
        loop_en = 1'b0;
        tick();
        total++;
        if (instr_valid !== 1'b1 || instr_out !== 7'h0B) begin
            bad++;
            $display("FAIL loop_tail: out=%0h v=%0b, required 0b 1", instr_out, instr_valid);
        end
        tick();
        total++;
        if (done !== 1'b1 || instr_valid !== 1'b0 || instr_out !== 7'h00) begin
            bad++;
            $display("FAIL loop_done: done=%0b v=%0b out=%0h, required 1 0 0",
                     done, instr_valid, instr_out);
        end
    endtask

    task automatic test_step();
        int k;
        logic       exp_v;
        logic [6:0] exp_o;
        prog.delete();
        for (int i = 0; i < 3; i++) prog.push_back(7'($urandom_range(1, 127)));
        load_prog();
        loop_en   = 1'b0;
        step_mode = 1'b1;
        start_run();
        k = 0;
        for (int c = 0; c < 13; c++) begin
            step  = (c == 3 || c == 4 || c == 9);
            exp_v = step && (k < 3);
            exp_o = exp_v ? prog[k] : 7'h00;
            tick();
            total++;
            if (instr_valid !== exp_v || instr_out !== exp_o) begin
                bad++;
                $display("FAIL step_cycle[%0d]: out=%0h v=%0b, required %0h %0b",
                         c, instr_out, instr_valid, exp_o, exp_v);
            end
            if (exp_v) k++;
        end
        step = 1'b0;
        total++;
        if (k !== 3 || done !== 1'b1) begin
            bad++;
            $display("FAIL step_done: issues=%0d done=%0b, required 3 1", k, done);
        end
        step_mode = 1'b0;
    endtask

    task automatic test_reset_midrun();
        prog.delete();
        for (int i = 0; i < 5; i++) prog.push_back(7'($urandom_range(1, 127)));
        load_prog();
        start_run();
        tick();
        tick();
        total++;
        if (pc !== 4'd2) begin
            bad++;
            $display("FAIL midrun_pc: pc=%0d, required 2", pc);
        end
        do_reset();
        total++;
        if (busy !== 1'b0 || instr_valid !== 1'b0 || instr_out !== 7'h00 ||
            prog_len !== 5'd0 || done !== 1'b0) begin
            bad++;
            $display("FAIL midrun_reset: busy=%0b v=%0b out=%0h len=%0d done=%0b, required all zero",
                     busy, instr_valid, instr_out, prog_len, done);
        end
        start_run();
        tick();
        total++;
        if (busy !== 1'b0 || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_start: busy=%0b v=%0b, required 0 0", busy, instr_valid);
        end
    endtask

    task automatic test_random(input int cycles);
        int         len;
        int         k;
        logic       adv;
        logic [6:0] exp_o;
        len = $urandom_range(1, 16);
        prog.delete();
        for (int i = 0; i < len; i++) prog.push_back(7'($urandom_range(0, 127)));
        load_prog();
        loop_en = 1'b1;
        start_run();
        k = 0;
        for (int c = 0; c < cycles; c++) begin
            step_mode = 1'($urandom_range(0, 1));
            step      = 1'($urandom_range(0, 1));
            adv       = !step_mode || step;
            exp_o     = adv ? prog[k] : 7'h00;
            tick();
            if (adv) k = (k + 1) % len;
            total++;
            if (instr_valid !== adv || instr_out !== exp_o || pc !== 4'(k) || busy !== 1'b1) begin
                bad++;
                $display("FAIL rand_cycle[%0d]: out=%0h v=%0b pc=%0d busy=%0b, required %0h %0b %0d 1",
                         c, instr_out, instr_valid, pc, busy, exp_o, adv, k);
            end
        end
        step_mode = 1'b0;
        step      = 1'b0;
        loop_en   = 1'b0;
        do_reset();
    endtask

    initial begin
        rst       = 1'b1;
        load_en   = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        start     = 1'b0;
        step_mode = 1'b0;
        step      = 1'b0;
        loop_en   = 1'b0;
        tick();
        test_reset();
        test_idle_start();
        do_reset();
        test_basic();
        do_reset();
        test_full();
        do_reset();
        test_loop();
        do_reset();
        test_step();
        do_reset();
        test_reset_midrun();
        do_reset();
        for (int r = 0; r < 3; r++) test_random(80);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
